// File: rtl/fifo_pkg.sv
// Shared types and constants for the Async_FIFO write-side producer.
package fifo_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} wr_state_t;

  typedef enum logic [1:0] {INCR, LFSR, FIXED} pat_mode_t;

  // x^8+x^6+x^5+x^4+1 in Galois right-shift form (DATA_LINES=8)
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Reserved encoding 3 behaves as FIXED
  function automatic pat_mode_t decode_mode(input logic [1:0] m);
    pat_mode_t r;
    case (m)
      2'd0:    r = INCR;
      2'd1:    r = LFSR;
      default: r = FIXED;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fifo_burst_writer_if.sv
// FIFO write-port bundle between the burst writer (master) and the FIFO (slave).
interface fifo_burst_writer_if #(
  parameter int DATA_LINES = 8
);
  logic                  winc;
  logic [DATA_LINES-1:0] wdata;
  logic                  wfull;
  logic                  half_full;

  modport master (output winc, output wdata, input wfull, input half_full);
  modport slave  (input winc, input wdata, output wfull, output half_full);
endinterface

// File: rtl/fifo_pattern_gen.sv
// Word pattern generator: loads the first word from seed, steps to the next word on advance.
module fifo_pattern_gen
  import fifo_pkg::*;
#(
  parameter int DATA_LINES = 8
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic                  load,
  input  logic                  advance,
  input  logic [1:0]            mode,
  input  logic [DATA_LINES-1:0] seed,
  output logic [DATA_LINES-1:0] data
);

  localparam logic [DATA_LINES-1:0] TAPS = DATA_LINES'(LFSR_TAPS);
  localparam logic [DATA_LINES-1:0] ONE  = DATA_LINES'(1);

  pat_mode_t             mode_q;
  pat_mode_t             load_mode;
  logic [DATA_LINES-1:0] first_word;
  logic [DATA_LINES-1:0] next_word;

  // An all-zero LFSR would lock up, so a zero seed starts from 1
  always_comb begin
    load_mode  = decode_mode(mode);
    first_word = seed;
    if (load_mode == LFSR && seed == '0) begin
      first_word = ONE;
    end
  end

  always_comb begin
    next_word = data;
    case (mode_q)
      INCR:    next_word = data + ONE;
      LFSR:    next_word = (data >> 1) ^ (data[0] ? TAPS : '0);
      default: next_word = data;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      mode_q <= INCR;
      data   <= '0;
    end else if (load) begin
      mode_q <= load_mode;
      data   <= first_word;
    end else if (advance) begin
      data   <= next_word;
    end
  end

endmodule

// File: rtl/fifo_burst_writer.sv
// Burst producer for the Async_FIFO write port: pushes burst_len pattern words,
// honouring wfull and optional half_full throttling, and keeps burst statistics.
module fifo_burst_writer
  import fifo_pkg::*;
#(
  parameter int DATA_LINES = 8,
  parameter int LEN_W      = 9,
  parameter int CNT_W      = 16
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [LEN_W-1:0]      burst_len,
  input  logic [1:0]            mode,
  input  logic [DATA_LINES-1:0] seed,
  input  logic                  throttle_en,
  fifo_burst_writer_if.master   fifo,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [CNT_W-1:0]      words_written,
  output logic [CNT_W-1:0]      stall_cycles
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  wr_state_t             state;
  wr_state_t             state_next;
  logic [LEN_W-1:0]      remaining;
  logic                  winc_q;
  logic                  accept;
  logic                  start_go;
  logic                  start_zero;
  logic                  advance;
  logic                  set_aborted;
  logic [DATA_LINES-1:0] pattern_data;

  assign accept = winc_q & ~fifo.wfull;

  always_comb begin
    state_next  = state;
    start_go    = 1'b0;
    start_zero  = 1'b0;
    advance     = 1'b0;
    set_aborted = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          start_go   = (burst_len != '0);
          start_zero = (burst_len == '0);
        end
        if (start_go) state_next = RUN;
      end
      RUN: begin
        if (abort) begin
          state_next  = IDLE;
          set_aborted = 1'b1;
        end else if (accept && remaining == LEN_ONE) begin
          state_next = DONE;
        end else begin
          advance = accept;
          if (throttle_en && fifo.half_full) state_next = PAUSE;
        end
      end
      PAUSE: begin
        if (abort) begin
          state_next  = IDLE;
          set_aborted = 1'b1;
        end else if (!fifo.half_full || !throttle_en) begin
          state_next = RUN;
        end
      end
      DONE: begin
        state_next  = IDLE;
        set_aborted = abort;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      state   <= IDLE;
      winc_q  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
    end else begin
      state   <= state_next;
      winc_q  <= (state_next == RUN);
      busy    <= (state_next == RUN) || (state_next == PAUSE);
      done    <= start_zero || (state == RUN && state_next == DONE);
      if (set_aborted) begin
        aborted <= 1'b1;
      end else if (start_go) begin
        aborted <= 1'b0;
      end
    end
  end

  // Statistics saturate and hold after DONE/abort until the next real start
  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      remaining     <= '0;
      words_written <= '0;
      stall_cycles  <= '0;
    end else if (start_go) begin
      remaining     <= burst_len;
      words_written <= '0;
      stall_cycles  <= '0;
    end else begin
      if (accept) begin
        remaining <= remaining - LEN_ONE;
        if (words_written != '1) words_written <= words_written + CNT_ONE;
      end
      if (winc_q && fifo.wfull && stall_cycles != '1) begin
        stall_cycles <= stall_cycles + CNT_ONE;
      end
    end
  end

  fifo_pattern_gen #(
    .DATA_LINES(DATA_LINES)
  ) u_pattern (
    .wclk    (wclk),
    .wrst    (wrst),
    .load    (start_go),
    .advance (advance),
    .mode    (mode),
    .seed    (seed),
    .data    (pattern_data)
  );

  assign fifo.winc  = winc_q;
  assign fifo.wdata = pattern_data;

endmodule

// File: tb/tb_fifo_burst_writer.sv
// Directed self-checking bench for fifo_burst_writer with hand-computed expectations.
module tb_fifo_burst_writer;

  logic       wclk = 1'b0;
  logic       wrst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [8:0] burst_len = '0;
  logic [1:0] mode = '0;
  logic [7:0] seed = '0;
  logic       throttle_en = 1'b0;
  logic       busy, done, aborted;
  logic [15:0] words_written, stall_cycles;

  int total = 0;
  int bad = 0;

  fifo_burst_writer_if #(.DATA_LINES(8)) fifo_bus ();

  fifo_burst_writer #(
    .DATA_LINES(8),
    .LEN_W(9),
    .CNT_W(16)
  ) dut (
    .wclk          (wclk),
    .wrst          (wrst),
    .start         (start),
    .abort         (abort),
    .burst_len     (burst_len),
    .mode          (mode),
    .seed          (seed),
    .throttle_en   (throttle_en),
    .fifo          (fifo_bus.master),
    .busy          (busy),
    .done          (done),
    .aborted       (aborted),
    .words_written (words_written),
    .stall_cycles  (stall_cycles)
  );

  always #5 wclk = ~wclk;

  task automatic tick();
    @(posedge wclk);
    @(negedge wclk);
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [8:0] len, input logic [1:0] m, input logic [7:0] s);
    start     = 1'b1;
    burst_len = len;
    mode      = m;
    seed      = s;
    tick();
    start     = 1'b0;
  endtask

  initial begin
    fifo_bus.wfull     = 1'b0;
    fifo_bus.half_full = 1'b0;
    @(negedge wclk);
    check_output("rst_winc",  32'(fifo_bus.winc), 32'h0);
    check_output("rst_wdata", 32'(fifo_bus.wdata), 32'h0);
    check_output("rst_busy",  32'(busy), 32'h0);
    check_output("rst_done",  32'(done), 32'h0);
    check_output("rst_abrt",  32'(aborted), 32'h0);
    check_output("rst_ww",    32'(words_written), 32'h0);
    check_output("rst_stall", 32'(stall_cycles), 32'h0);
    wrst = 1'b1;
    tick();

    $display("[TB] incrementing burst with wrap");
    apply_stimulus(9'd4, 2'd0, 8'hFE);
    check_output("t1_winc0", 32'(fifo_bus.winc), 32'h1);
    check_output("t1_busy",  32'(busy), 32'h1);
    check_output("t1_w0",    32'(fifo_bus.wdata), 32'hFE);
    tick();
    check_output("t1_w1",    32'(fifo_bus.wdata), 32'hFF);
    tick();
    check_output("t1_w2",    32'(fifo_bus.wdata), 32'h00);
    tick();
    check_output("t1_w3",    32'(fifo_bus.wdata), 32'h01);
    check_output("t1_winc3", 32'(fifo_bus.winc), 32'h1);
    tick();
    check_output("t1_done",  32'(done), 32'h1);
    check_output("t1_wincd", 32'(fifo_bus.winc), 32'h0);
    check_output("t1_ww",    32'(words_written), 32'h4);
    tick();
    check_output("t1_done_off", 32'(done), 32'h0);
    check_output("t1_idle",     32'(busy), 32'h0);

    $display("[TB] full back-pressure");
    apply_stimulus(9'd3, 2'd0, 8'h10);
    fifo_bus.wfull = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_output("t2_hold", 32'(fifo_bus.wdata), 32'h10);
      check_output("t2_winc", 32'(fifo_bus.winc), 32'h1);
    end
    fifo_bus.wfull = 1'b0;
    check_output("t2_stall5", 32'(stall_cycles), 32'h5);
    check_output("t2_ww0",    32'(words_written), 32'h0);
    tick();
    check_output("t2_w1", 32'(fifo_bus.wdata), 32'h11);
    tick();
    check_output("t2_w2", 32'(fifo_bus.wdata), 32'h12);
    tick();
    check_output("t2_done",  32'(done), 32'h1);
    check_output("t2_ww",    32'(words_written), 32'h3);
    check_output("t2_stall", 32'(stall_cycles), 32'h5);
    tick();

    $display("[TB] lfsr with zero seed");
    apply_stimulus(9'd3, 2'd1, 8'h00);
    check_output("t3_w0", 32'(fifo_bus.wdata), 32'h01);
    tick();
    check_output("t3_w1", 32'(fifo_bus.wdata), 32'hB8);
    tick();
    check_output("t3_w2", 32'(fifo_bus.wdata), 32'h5C);
    tick();
    check_output("t3_done", 32'(done), 32'h1);
    tick();

    $display("[TB] half-full throttling");
    throttle_en = 1'b1;
    apply_stimulus(9'd4, 2'd0, 8'h20);
    check_output("t4_w0", 32'(fifo_bus.wdata), 32'h20);
    tick();
    check_output("t4_w1", 32'(fifo_bus.wdata), 32'h21);
    fifo_bus.half_full = 1'b1;
    tick();
    check_output("t4_pause_winc", 32'(fifo_bus.winc), 32'h0);
    check_output("t4_pause_busy", 32'(busy), 32'h1);
    check_output("t4_pause_ww",   32'(words_written), 32'h2);
    check_output("t4_pause_w",    32'(fifo_bus.wdata), 32'h22);
    tick();
    check_output("t4_pause_winc2", 32'(fifo_bus.winc), 32'h0);
    check_output("t4_pause_w2",    32'(fifo_bus.wdata), 32'h22);
    fifo_bus.half_full = 1'b0;
    tick();
    check_output("t4_resume_winc", 32'(fifo_bus.winc), 32'h1);
    check_output("t4_resume_w",    32'(fifo_bus.wdata), 32'h22);
    tick();
    check_output("t4_w3", 32'(fifo_bus.wdata), 32'h23);
    tick();
    check_output("t4_done", 32'(done), 32'h1);
    check_output("t4_ww",   32'(words_written), 32'h4);
    throttle_en = 1'b0;
    tick();

    $display("[TB] abort mid-burst");
    apply_stimulus(9'd10, 2'd0, 8'h00);
    tick();
    tick();
    tick();
    check_output("t5_w3", 32'(fifo_bus.wdata), 32'h03);
    abort = 1'b1;
    fifo_bus.wfull = 1'b1;
    tick();
    abort = 1'b0;
    fifo_bus.wfull = 1'b0;
    check_output("t5_winc",    32'(fifo_bus.winc), 32'h0);
    check_output("t5_busy",    32'(busy), 32'h0);
    check_output("t5_aborted", 32'(aborted), 32'h1);
    check_output("t5_nodone",  32'(done), 32'h0);
    check_output("t5_ww",      32'(words_written), 32'h3);
    tick();
    check_output("t5_nodone2", 32'(done), 32'h0);
    check_output("t5_sticky",  32'(aborted), 32'h1);
    apply_stimulus(9'd2, 2'd2, 8'h5A);
    check_output("t5_clr",     32'(aborted), 32'h0);
    check_output("t5_ww_clr",  32'(words_written), 32'h0);
    check_output("t5_fix0",    32'(fifo_bus.wdata), 32'h5A);
    tick();
    check_output("t5_fix1",    32'(fifo_bus.wdata), 32'h5A);
    check_output("t5_ww1",     32'(words_written), 32'h1);
    tick();
    check_output("t5_done",    32'(done), 32'h1);
    tick();

    $display("[TB] zero-length burst and mid-burst reset");
    apply_stimulus(9'd0, 2'd0, 8'h33);
    check_output("t6_done",  32'(done), 32'h1);
    check_output("t6_winc",  32'(fifo_bus.winc), 32'h0);
    check_output("t6_busy",  32'(busy), 32'h0);
    tick();
    check_output("t6_done_off", 32'(done), 32'h0);
    check_output("t6_winc2",    32'(fifo_bus.winc), 32'h0);
    apply_stimulus(9'd5, 2'd0, 8'h40);
    tick();
    check_output("t6_mid_winc", 32'(fifo_bus.winc), 32'h1);
    check_output("t6_mid_w",    32'(fifo_bus.wdata), 32'h41);
    wrst = 1'b0;
    #1;
    check_output("t6_rst_winc",  32'(fifo_bus.winc), 32'h0);
    check_output("t6_rst_wdata", 32'(fifo_bus.wdata), 32'h0);
    check_output("t6_rst_busy",  32'(busy), 32'h0);
    check_output("t6_rst_ww",    32'(words_written), 32'h0);
    tick();
    wrst = 1'b1;
    tick();
    check_output("t6_after_winc", 32'(fifo_bus.winc), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
